// File: rtl/trap_sequencer.sv
// Writeback-stage trap/return sequencer feeding the CSR file and front-end redirect.
// Optional external-interrupt support is compiled in with `define TRAP_INTERRUPT_EN.
module trap_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wbValid,
    input  logic [XLEN-1:0] wbPC,
    input  logic            wbExcPending,
    input  logic [3:0]      wbExcCause,
    input  logic [XLEN-1:0] wbExcTval,
    input  logic            wbMret,
    input  logic [XLEN-1:0] trapVector,
    input  logic [XLEN-1:0] mepcValue,
    input  logic            mstatusMIE,
    input  logic            interrupt,
    output logic            controlReset,
    output logic [3:0]      mcause,
    output logic [XLEN-1:0] mtval,
    output logic            mretSignal,
    output logic            trapIsInterrupt,
    output logic            redirectValid,
    output logic [XLEN-1:0] redirectPC,
    output logic            pipeFlush
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       int_take;
    logic       unused_inputs;

    // MEPC capture of wbPC happens inside the CSR file, not here.
`ifdef TRAP_INTERRUPT_EN
    logic int_meta_q, int_meta_d;
    logic int_sync_q, int_sync_d;

    assign int_meta_d    = interrupt;
    assign int_sync_d    = int_meta_q;
    assign int_take      = int_sync_q && mstatusMIE && wbValid && !wbExcPending;
    assign unused_inputs = ^{wbPC, trapVector[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            int_meta_q <= int_meta_d;
            int_sync_q <= int_sync_d;
        end
    end
`else
    assign int_take      = 1'b0;
    assign unused_inputs = ^{interrupt, mstatusMIE, wbPC, trapVector[1:0]};
`endif

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        controlReset    = 1'b0;
        mcause          = 4'd0;
        mtval           = '0;
        mretSignal      = 1'b0;
        trapIsInterrupt = 1'b0;
        redirectValid   = 1'b0;
        redirectPC      = '0;
        pipeFlush       = 1'b0;

        // Outputs are gated during reset so a mid-flush reset drops everything at once.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (wbValid && wbExcPending) begin
                        controlReset  = 1'b1;
                        mcause        = wbExcCause;
                        mtval         = wbExcTval;
                        redirectValid = 1'b1;
                        redirectPC    = {trapVector[XLEN-1:2], 2'b00};
                        pipeFlush     = 1'b1;
                    end else if (int_take) begin
                        controlReset    = 1'b1;
                        mcause          = 4'd11;
                        trapIsInterrupt = 1'b1;
                        redirectValid   = 1'b1;
                        redirectPC      = {trapVector[XLEN-1:2], 2'b00};
                        pipeFlush       = 1'b1;
                    end else if (wbValid && wbMret) begin
                        mretSignal    = 1'b1;
                        redirectValid = 1'b1;
                        redirectPC    = mepcValue;
                        pipeFlush     = 1'b1;
                    end

                    // The strobe cycle itself is the first flush cycle.
                    if (redirectValid) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_LOAD != 3'd0) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    pipeFlush = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
